fft_agu_ctrl: RTL
=================

Name: fft_agu_ctrl

Overview:
- Address-generation unit and sequencer for the in-place radix-2 DIT FFT core.
- Sits directly upstream of the RAM top and drives its FFT-side controls: fft_rd_address1/2, fft_read_en, fft_wr_address1/2, fft_wr_en, fft_busy and bank_select.
- Walks log2(N) stages of N/2 butterflies each and supplies the twiddle index to the butterfly datapath.
- Delays write-back addresses to match butterfly pipeline latency and ping-pongs banks per stage.

Parameters:
- N, 32, FFT length; power of two, >= 4.
- address_width, $clog2(N), sample address width.
- BF_LATENCY, 3, cycles from read_en/read address issue to the matching butterfly result being ready for write; >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to run a full FFT; honoured only in IDLE.
- busy  output  1  FFT in progress; drives fft_busy.
- done  output  1  one-cycle pulse after the last write of the last stage.
- rd_address1  output  address_width  butterfly top-leg read address.
- rd_address2  output  address_width  butterfly bottom-leg read address.
- read_en  output  1  read strobe.
- wr_address1  output  address_width  write-back address, top leg.
- wr_address2  output  address_width  write-back address, bottom leg.
- wr_en  output  1  write strobe.
- twiddle_index  output  address_width-1  W_N^k index, aligned with read_en.
- bank_select  output  1  reads come from bank bank_select; writes go to the other bank.
- stage  output  $clog2(address_width)  current stage index.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all outputs 0; counters and delay line cleared. Reset mid-operation aborts immediately; no partial writes follow deassertion.
- States:
  - IDLE: busy=0. start=1 -> RUN with stage=0, j=0, bank_select=0, busy=1 from the next cycle.
  - RUN: read_en=1 for exactly N/2 consecutive cycles, j=0..N/2-1. After j=N/2-1 -> DRAIN.
  - DRAIN: read_en=0 for exactly BF_LATENCY cycles. Exit rules:
    - stage < log2(N)-1: toggle bank_select, increment stage, clear j, go to RUN.
    - otherwise: go to DONE.
  - DONE: done=1 and busy=0 for one cycle; bank_select holds the result bank; -> IDLE.
- Address rule for stage s, butterfly j:
  - half = 2^s; pos = j mod half; grp = j >> s.
  - rd_address1 = grp*2*half + pos; rd_address2 = rd_address1 + half.
  - twiddle_index = pos << (log2(N)-1-s).
  - All arithmetic is unsigned and never exceeds N-1, so no wrap is possible.
- Write-back: wr_address1/2 and wr_en are rd_address1/2 and read_en delayed by exactly BF_LATENCY cycles through a shift register. The last write of each stage lands in the final DRAIN cycle.
- Stage changes only after the drain completes, so reads never overlap writes of the previous stage.
- Total busy time = log2(N)*(N/2+BF_LATENCY) cycles. For N=32 and BF_LATENCY=3 this is 95 cycles.
- start while busy or in DONE is ignored and not queued.
- Input data is expected in bit-reversed order in bank 0; loading it is the IO side's job.
- wr_en is never 1 in IDLE.

Optional Feature:
- Macro: FFT_AGU_STALL_EN.
- Defined: adds input stall (1 bit). While stall=1:
  - j, stage, the FSM and the write delay line all freeze.
  - read_en and wr_en are forced to 0.
  - Addresses hold their values.
  - Released cleanly with no lost or duplicated butterflies.
  - Busy time grows by exactly the number of stalled cycles.
- Undefined: no stall port; behaviour as above.

Test Plan:
- Reset/idle: reset=0 mid-RUN -> all outputs 0 next edge. Release reset with start=0 for 20 cycles -> busy=0, read_en=0, wr_en=0.
- N=8, BF_LATENCY=3, stage 0 sequence: start -> read pairs (0,1),(2,3),(4,5),(6,7) on 4 consecutive cycles, twiddle 0 on all, bank_select=0. wr_en pulses with the same pairs 3 cycles later.
- N=8 later stages:
  - stage 1, j=3 -> (5,7), twiddle 2, bank_select=1.
  - stage 2, j=1 -> (1,5), twiddle 1, bank_select=0.
- Timing: N=32 -> busy high 95 cycles, done pulse on cycle 96, final bank_select=0 (5 stages, 4 toggles). Exactly 80 read_en and 80 wr_en cycles.
- start asserted during RUN and during DONE -> ignored; next start after IDLE restarts at stage 0, j=0.
- FFT_AGU_STALL_EN: stall=1 for 5 cycles at stage 1, j=2 -> strobes 0, addresses held. Resumes at j=2; busy = 95+5 cycles for N=32.

Source files
------------

// File: rtl/fft_agu_ctrl.sv
// fft_agu_ctrl: address generator and sequencer for the in-place radix-2 DIT FFT.
// Walks log2(N) stages of N/2 butterflies and ping-pongs the RAM banks per stage.
// Ports: clk, reset (async, active-low), start -> busy, done, rd_address1/2, read_en,
//   wr_address1/2, wr_en (read side delayed BF_LATENCY), twiddle_index, bank_select, stage.
// Optional FFT_AGU_STALL_EN adds a stall input that freezes the whole sequencer.
module fft_agu_ctrl #(
  parameter int N             = 32,
  parameter int address_width = $clog2(N),
  parameter int BF_LATENCY    = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
`ifdef FFT_AGU_STALL_EN
  input  logic                               stall,
`endif
  output logic                               busy,
  output logic                               done,
  output logic [address_width-1:0]           rd_address1,
  output logic [address_width-1:0]           rd_address2,
  output logic                               read_en,
  output logic [address_width-1:0]           wr_address1,
  output logic [address_width-1:0]           wr_address2,
  output logic                               wr_en,
  output logic [address_width-2:0]           twiddle_index,
  output logic                               bank_select,
  output logic [$clog2(address_width)-1:0]   stage
);

  localparam int AW = address_width;
  localparam int JW = address_width - 1;
  localparam int SW = $clog2(address_width);
  localparam int CW = $clog2(BF_LATENCY + 1);

  localparam logic [JW-1:0] J_LAST = JW'(N / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(address_width - 1);
  localparam logic [CW-1:0] C_LAST = CW'(BF_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [JW-1:0]   j_q, j_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            bank_q, bank_d;
  logic            hold;
  logic            run;

`ifdef FFT_AGU_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      j_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    if (!hold) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            j_d     = '0;
            stage_d = '0;
            bank_d  = 1'b0;
          end
        end
        RUN: begin
          if (j_q == J_LAST) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            j_d = j_q + JW'(1);
          end
        end
        DRAIN: begin
          if (cnt_q == C_LAST) begin
            if (stage_q == S_LAST) begin
              state_d = DONE;
            end else begin
              state_d = RUN;
              stage_d = stage_q + SW'(1);
              j_d     = '0;
              bank_d  = ~bank_q;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Butterfly j of stage s: top leg = 2*j - (j mod 2^s), bottom leg = top + 2^s.
  logic [AW-1:0] jx, half, pos, a1, a2, tw;

  always_comb begin
    jx   = {1'b0, j_q};
    half = AW'(1) << stage_q;
    pos  = jx & (half - AW'(1));
    a1   = (jx << 1) - pos;
    a2   = a1 + half;
    tw   = pos << (S_LAST - stage_q);
  end

  assign run           = (state_q == RUN);
  assign read_en       = run & ~hold;
  assign rd_address1   = run ? a1 : '0;
  assign rd_address2   = run ? a2 : '0;
  assign twiddle_index = run ? tw[AW-2:0] : '0;
  assign busy          = (state_q == RUN) | (state_q == DRAIN);
  assign done          = (state_q == DONE) & ~hold;
  assign bank_select   = bank_q;
  assign stage         = stage_q;

  // Write-back line: read strobe and addresses re-emerge BF_LATENCY cycles later.
  logic          dl_en [BF_LATENCY];
  logic [AW-1:0] dl_a1 [BF_LATENCY];
  logic [AW-1:0] dl_a2 [BF_LATENCY];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BF_LATENCY; i++) begin
        dl_en[i] <= 1'b0;
        dl_a1[i] <= '0;
        dl_a2[i] <= '0;
      end
    end else if (!hold) begin
      dl_en[0] <= run;
      dl_a1[0] <= rd_address1;
      dl_a2[0] <= rd_address2;
      for (int i = 1; i < BF_LATENCY; i++) begin
        dl_en[i] <= dl_en[i-1];
        dl_a1[i] <= dl_a1[i-1];
        dl_a2[i] <= dl_a2[i-1];
      end
    end
  end

  assign wr_en       = dl_en[BF_LATENCY-1] & ~hold;
  assign wr_address1 = dl_a1[BF_LATENCY-1];
  assign wr_address2 = dl_a2[BF_LATENCY-1];

endmodule
